game_tick_gen: RTL and testbench

Parametrised clock-enable and game-tick generator for the Tetris core, driven from the board clock. Produces:
- a divided pixel clock and a matching one-cycle pixel enable for the VGA path;
- a one-cycle gameplay tick (`clk_playable`) whose period shortens with game level, with a soft-drop fast mode, pause, single-step and synchronous restart.

It replaces the fixed divide-by-4 / fixed-period timer.

---
 rtl/game_tick_gen.sv | 156 +++++++++++++++
 tb/tb_game_tick_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_gen.sv
// Tetris timing core: pixel clock/enable divider plus a level-scaled gameplay tick
// with soft-drop, pause, single-step and synchronous restart.
module game_tick_gen #(
  parameter int PIX_DIV     = 4,
  parameter int CNT_W       = 32,
  parameter int BASE_PERIOD = 75000000,
  parameter int LEVEL_STEP  = 7500000,
  parameter int MIN_PERIOD  = 5000000,
  parameter int FAST_PERIOD = 5000000,
  parameter int NUM_LEVELS  = 8,
  localparam int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             pause,
  input  logic             step,
  input  logic             fast,
  input  logic             level_up,
  input  logic             restart,
  output logic             clk_out,
  output logic             pix_en,
  output logic             clk_playable,
  output logic [LVL_W-1:0] level,
  output logic [15:0]      tick_count
);

  localparam int PIX_W  = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam int PROD_W = CNT_W + LVL_W;

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
  localparam logic [PIX_W-1:0]  PIX_HALF  = PIX_W'(PIX_DIV / 2 - 1);
  localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0]  BASE_C    = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  FAST_C    = CNT_W'(FAST_PERIOD);
  localparam logic [PROD_W-1:0] STEP_C    = PROD_W'(LEVEL_STEP);
  localparam logic [PROD_W-1:0] HEADROOM  = PROD_W'(BASE_PERIOD - MIN_PERIOD);

  logic [PIX_W-1:0]  pix_cnt_r;
  logic              clk_out_r;
  logic              pix_en_r;
  logic [LVL_W-1:0]  level_r;
  logic [CNT_W-1:0]  period_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              tick_r;
  logic [15:0]       tick_count_r;

  logic [PROD_W-1:0] prod_s;
  logic [CNT_W-1:0]  period_next_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              tick_next_s;
  logic              clear_tc_s;

  // Free-running pixel divider; ignores all gameplay controls.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pix_cnt_r <= {PIX_W{1'b0}};
      pix_en_r  <= 1'b0;
      clk_out_r <= 1'b0;
    end else begin
      if (pix_cnt_r == PIX_LAST) begin
        pix_cnt_r <= {PIX_W{1'b0}};
      end else begin
        pix_cnt_r <= pix_cnt_r + PIX_W'(1);
      end
      pix_en_r <= (pix_cnt_r == PIX_LAST);
      if ((pix_cnt_r == PIX_HALF) || (pix_cnt_r == PIX_LAST)) begin
        clk_out_r <= ~clk_out_r;
      end else begin
        clk_out_r <= clk_out_r;
      end
    end
  end

  // Level register: restart wins over level_up, which saturates at the top level.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      level_r <= {LVL_W{1'b0}};
    end else if (restart) begin
      level_r <= {LVL_W{1'b0}};
    end else if (level_up && (level_r < LVL_MAX)) begin
      level_r <= level_r + LVL_W'(1);
    end else begin
      level_r <= level_r;
    end
  end

  // Period select; the product is checked against the headroom so the subtraction cannot wrap.
  always_comb begin
    prod_s        = PROD_W'(level_r) * STEP_C;
    period_next_s = BASE_C;
    if (fast) begin
      period_next_s = FAST_C;
    end else if (prod_s > HEADROOM) begin
      period_next_s = MIN_C;
    end else begin
      period_next_s = BASE_C - prod_s[CNT_W-1:0];
    end
  end

  // Registered period keeps the long multiply/compare off the counter path.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period_r <= BASE_C;
    end else begin
      period_r <= period_next_s;
    end
  end

  // Tick decision; >= lets a shrinking period fire immediately rather than wrap.
  always_comb begin
    cnt_next_s  = cnt_r;
    tick_next_s = 1'b0;
    clear_tc_s  = 1'b0;
    if (restart) begin
      cnt_next_s = {CNT_W{1'b0}};
      clear_tc_s = 1'b1;
    end else if (pause && step) begin
      cnt_next_s  = {CNT_W{1'b0}};
      tick_next_s = 1'b1;
    end else if (pause) begin
      cnt_next_s = cnt_r;
    end else if (cnt_r >= (period_r - CNT_W'(1))) begin
      cnt_next_s  = {CNT_W{1'b0}};
      tick_next_s = 1'b1;
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Tick counter, gameplay pulse and wrapping tick tally.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_r        <= {CNT_W{1'b0}};
      tick_r       <= 1'b0;
      tick_count_r <= 16'd0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= tick_next_s;
      if (clear_tc_s) begin
        tick_count_r <= 16'd0;
      end else if (tick_next_s) begin
        tick_count_r <= tick_count_r + 16'd1;
      end else begin
        tick_count_r <= tick_count_r;
      end
    end
  end

  assign clk_out      = clk_out_r;
  assign pix_en       = pix_en_r;
  assign clk_playable = tick_r;
  assign level        = level_r;
  assign tick_count   = tick_count_r;

endmodule

// File: tb/tb_game_tick_gen.sv
// Self-checking bench for game_tick_gen: directed scenarios plus random control
// traffic, compared every cycle against an arithmetic model of the tick rules.
module tb_game_tick_gen;

  localparam int PD    = 4;
  localparam int BASE  = 20;
  localparam int STEPP = 4;
  localparam int MINP  = 6;
  localparam int FASTP = 3;
  localparam int NLV   = 8;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0, step = 1'b0, fast = 1'b0, level_up = 1'b0, restart = 1'b0;
  logic        clk_out, pix_en, clk_playable;
  logic [2:0]  level;
  logic [15:0] tick_count;

  integer total = 0;
  integer bad = 0;

  game_tick_gen #(
    .PIX_DIV(PD), .CNT_W(32), .BASE_PERIOD(BASE), .LEVEL_STEP(STEPP),
    .MIN_PERIOD(MINP), .FAST_PERIOD(FASTP), .NUM_LEVELS(NLV)
  ) dut (
    .clk_in(clk_in), .rst(rst), .pause(pause), .step(step), .fast(fast),
    .level_up(level_up), .restart(restart), .clk_out(clk_out), .pix_en(pix_en),
    .clk_playable(clk_playable), .level(level), .tick_count(tick_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset, level, period and counter as plain integers.
  int m_n = 0, m_lvl = 0, m_per = BASE, m_cnt = 0, m_tc = 0;
  int m_tick = 0, m_pe = 0, m_co = 0, new_per = 0;

  always @(posedge clk_in) begin
    #1;
    if (rst) begin
      m_n = 0; m_lvl = 0; m_per = BASE; m_cnt = 0; m_tc = 0;
      m_tick = 0; m_pe = 0; m_co = 0;
    end else begin
      if (fast) new_per = FASTP;
      else if (BASE - m_lvl * STEPP < MINP) new_per = MINP;
      else new_per = BASE - m_lvl * STEPP;
      m_tick = 0;
      if (restart) begin
        m_cnt = 0; m_tc = 0;
      end else if (pause && step) begin
        m_tick = 1; m_cnt = 0;
      end else if (pause) begin
        m_tick = 0;
      end else if (m_cnt + 1 >= m_per) begin
        m_tick = 1; m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (m_tick == 1) m_tc = (m_tc + 1) % 65536;
      if (restart) m_lvl = 0;
      else if (level_up && m_lvl < NLV - 1) m_lvl = m_lvl + 1;
      m_per = new_per;
      m_n   = m_n + 1;
      m_pe  = (m_n % PD == 0) ? 1 : 0;
      m_co  = (m_n / (PD / 2)) % 2;
    end
    chk("model_clk_out", 32'(clk_out), 32'(m_co));
    chk("model_pix_en", 32'(pix_en), 32'(m_pe));
    chk("model_tick", 32'(clk_playable), 32'(m_tick));
    chk("model_level", 32'(level), 32'(m_lvl));
    chk("model_tick_count", 32'(tick_count), 32'(m_tc));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse_lvl(input int n);
    for (int i = 0; i < n; i++) begin
      level_up = 1'b1; cyc(1); level_up = 1'b0; cyc(1);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1; cyc(1); restart = 1'b0;
  endtask

  int k;

  initial begin
    // Reset state
    cyc(3);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_pix_en", 32'(pix_en), 32'd0);
    chk("rst_tick", 32'(clk_playable), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_tick_count", 32'(tick_count), 32'd0);
    rst = 1'b0;

    // Scenario 1: free running, first tick at edge 20
    cyc(2);
    chk("s1_clk_out_e2", 32'(clk_out), 32'd1);
    cyc(2);
    chk("s1_pix_en_e4", 32'(pix_en), 32'd1);
    cyc(15);
    chk("s1_no_tick_e19", 32'(clk_playable), 32'd0);
    cyc(1);
    chk("s1_tick_e20", 32'(clk_playable), 32'd1);
    cyc(40);
    chk("s1_tick_e60", 32'(clk_playable), 32'd1);
    chk("s1_count_e60", 32'(tick_count), 32'd3);

    // Scenario 2: level ramp and saturation
    pulse_lvl(3);
    chk("s2_level3", 32'(level), 32'd3);
    cyc(30);
    pulse_lvl(2);
    chk("s2_level5", 32'(level), 32'd5);
    cyc(25);
    pulse_lvl(10);
    chk("s2_level_sat", 32'(level), 32'd7);
    cyc(25);

    // Scenario 3: pause at cnt=7, resume, then single step
    do_restart();
    cyc(7);
    pause = 1'b1;
    cyc(50);
    chk("s3_paused_count", 32'(tick_count), 32'd0);
    pause = 1'b0;
    k = 0;
    do begin
      cyc(1); k = k + 1;
    end while (!clk_playable && k < 40);
    chk("s3_resume_delay", 32'(k), 32'd13);
    cyc(5);
    pause = 1'b1;
    cyc(3);
    step = 1'b1; cyc(1); step = 1'b0;
    chk("s3_step_tick", 32'(clk_playable), 32'd1);
    cyc(1);
    chk("s3_step_single", 32'(clk_playable), 32'd0);
    cyc(10);
    pause = 1'b0;
    cyc(25);

    // Scenario 4: fast mode mid-count, then back to normal
    do_restart();
    cyc(10);
    fast = 1'b1;
    cyc(12);
    fast = 1'b0;
    cyc(45);

    // Scenario 5: restart and level_up together at level 4
    do_restart();
    pulse_lvl(4);
    chk("s5_level4", 32'(level), 32'd4);
    restart = 1'b1; level_up = 1'b1; cyc(1); restart = 1'b0; level_up = 1'b0;
    chk("s5_level0", 32'(level), 32'd0);
    chk("s5_count0", 32'(tick_count), 32'd0);
    cyc(20);

    // Random control traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) pause = ~pause;
      step     = ($urandom_range(5) == 0);
      if ($urandom_range(39) == 0) fast = ~fast;
      level_up = ($urandom_range(29) == 0);
      restart  = ($urandom_range(199) == 0);
      cyc(1);
    end
    pause = 1'b0; step = 1'b0; fast = 1'b0; level_up = 1'b0; restart = 1'b0;
    cyc(30);

    // Scenario 6: asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("s6_async_clk_out", 32'(clk_out), 32'd0);
    chk("s6_async_pix_en", 32'(pix_en), 32'd0);
    chk("s6_async_tick", 32'(clk_playable), 32'd0);
    chk("s6_async_level", 32'(level), 32'd0);
    chk("s6_async_count", 32'(tick_count), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(19);
    chk("s6_no_tick_e19", 32'(clk_playable), 32'd0);
    cyc(1);
    chk("s6_tick_e20", 32'(clk_playable), 32'd1);
    chk("s6_count1", 32'(tick_count), 32'd1);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
